dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the multi-cycle processor's data-memory port. It replaces the zero-latency data memory with a handshaked slave. It accepts one load/store request at a time, holds it for a fixed number of wait cycles, commits it to an internal word array, and presents a response that the processor controller must acknowledge. It sits between the ALU-output/B-register address/data path and the memory-data register.

## Interface
Parameters:
- DATA_WIDTH, 32, data and byte-address width
- ADDR_WIDTH, 8, word-index width; depth = 2^ADDR_WIDTH words
- LATENCY, 2, wait cycles from request acceptance to response; legal range 1..15

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears FSM and outputs
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  DATA_WIDTH  byte address; word index = req_addr[ADDR_WIDTH+1:2]
- req_wdata  in  DATA_WIDTH  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
- rsp_err  out  1  misaligned or out-of-range access

## Operation
- FSM states: S_IDLE, S_WAIT, S_RESP.
- S_IDLE:
  - req_ready = 1.
  - When req_valid && req_ready at an edge, latch write, addr and wdata; load cnt = LATENCY-1; go to S_WAIT.
- S_WAIT:
  - req_ready = 0; rsp_valid = 0.
  - If cnt == 0, do the access on this edge and go to S_RESP. Otherwise decrement cnt.
- Access at the S_WAIT exit edge:
  - err = (addr[1:0] != 0) || (addr[DATA_WIDTH-1:ADDR_WIDTH+2] != 0).
  - Store without err: array[idx] <= wdata; rsp_rdata <= 0.
  - Load without err: rsp_rdata <= array[idx].
  - Any err: no array write; rsp_rdata <= 0; rsp_err <= 1.
- S_RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable.
  - On rsp_ready go to S_IDLE; rsp_valid, rsp_err and rsp_rdata clear to 0.
- Request inputs are ignored outside S_IDLE. The requester must hold the request until req_ready.
- rsp_ready outside S_RESP has no effect.
- Only one transaction is outstanding, so load-after-store to the same address always returns the stored data.
- Array contents are not cleared by reset. The bench writes before it reads.

## Timing
- Reset values: state S_IDLE, cnt 0, rsp_valid 0, rsp_err 0, rsp_rdata 0.
- req_ready is 0 while reset is high and 1 in the first cycle after release.
- rsp_valid rises exactly LATENCY clocks after the accepting edge. With LATENCY=2: accept at edge k, rsp_valid high after edge k+2.
- The response handshake edge returns the FSM to S_IDLE. The next request can be accepted no earlier than the following edge, so the minimum transaction period is LATENCY+2 cycles with rsp_ready tied high.
- req_ready is a decode of state only, with no combinational path from req_valid.
- rsp_valid is registered.
- Reset asserted in S_WAIT: the pending store is discarded and the array is unchanged.
- Reset asserted in S_RESP: the response is dropped and the store, already committed, remains.
- Reset asserted on the same edge as acceptance: reset wins and nothing is latched.

## Structure
- Shared package `mem_if_pkg`:
  - state encodings S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2
  - default DATA_WIDTH/ADDR_WIDTH/LATENCY constants
  - error-check width helper
- Sub-module `dmem_array`:
  - parameterised DATA_WIDTH × 2^ADDR_WIDTH storage
  - synchronous write enable, combinational read
  - no reset
- Top level holds the FSM, latency counter, request latches and response registers.

## Test plan
- Reset then release with req_valid=0 → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- LATENCY=2, rsp_ready=1:
  - store 0xDEADBEEF to 0x10 → rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0
  - then load 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0
- Load 0x10 with rsp_ready held 0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0. A req_valid pulse during this window is ignored. After rsp_ready=1, req_ready=1 on the next cycle.
- Misaligned store of 0x12345678 to 0x13, then out-of-range load of 0x400 (ADDR_WIDTH=8):
  - both complete with rsp_err=1 and rsp_rdata=0
  - load of 0x10 still returns 0xDEADBEEF
- Store 0xCAFEF00D to 0x10, reset pulse one cycle after accept (in S_WAIT) → FSM returns to S_IDLE; load 0x10 returns 0xDEADBEEF.
- LATENCY=1 and LATENCY=15 builds → back-to-back loads with rsp_ready=1 measure exactly LATENCY cycles accept-to-rsp_valid and LATENCY+2 cycles per transaction.

Source files
------------

// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_if_pkg
// Purpose  : Shared types and constants for the data-memory responder:
//            FSM state encoding, default geometry and an address-check helper.
// Revision : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

    // Responder FSM state encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Default geometry and timing
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_LATENCY    = 2;

    // Latency counter width; covers LATENCY-1 for LATENCY up to 15
    localparam int CNT_WIDTH = 4;

    // Number of byte-address bits above the word index that must be zero
    // for an in-range access (two byte-offset bits sit below the index).
    function automatic int hi_addr_width(input int dw, input int aw);
        return dw - aw - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : DATA_WIDTH x 2^ADDR_WIDTH word storage, synchronous write,
//            combinational read. Contents are deliberately not reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Word write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Handshaked data-memory slave. Accepts one load/store, waits
//            LATENCY cycles, commits to the word array and holds a response
//            until the requester acknowledges it.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int                   c_HI_W     = hi_addr_width(DATA_WIDTH, ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] c_CNT_INIT = CNT_WIDTH'(LATENCY - 1);

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_hi_err;
    logic                  w_err;
    logic                  w_access;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_idx = r_addr[ADDR_WIDTH+1:2];

    // Out-of-range check only exists when the byte address is wider than
    // the word index plus byte offset.
    generate
        if (c_HI_W > 0) begin : g_hi_chk
            assign w_hi_err = |r_addr[DATA_WIDTH-1:ADDR_WIDTH+2];
        end else begin : g_no_hi_chk
            assign w_hi_err = 1'b0;
        end
    endgenerate

    assign w_err    = (r_addr[1:0] != 2'b00) || w_hi_err;
    assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
    // Reset gating keeps a store pending in S_WAIT from ever committing
    assign w_we     = w_access && r_write && !w_err && !reset;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    // Pure state decode, forced low while reset is held
    assign req_ready = (r_state == S_IDLE) && !reset;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

    // Request/wait/response FSM with latency counter and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (r_write || w_err) ? '0 : w_rdata;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder (LATENCY 2, 1, 15)
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int c_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .LATENCY    (c_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // LATENCY=1 (index 0) and LATENCY=15 (index 1) instances
    logic        lv   [2];
    logic        lw   [2];
    logic [31:0] la   [2];
    logic [31:0] lwd  [2];
    logic        lrdy [2];
    logic        lrv  [2];
    logic [31:0] lrd  [2];
    logic        lerr [2];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_lat
            dmem_responder #(
                .DATA_WIDTH (32),
                .ADDR_WIDTH (8),
                .LATENCY    ((g == 0) ? 1 : 15)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .req_valid (lv[g]),
                .req_ready (lrdy[g]),
                .req_write (lw[g]),
                .req_addr  (la[g]),
                .req_wdata (lwd[g]),
                .rsp_valid (lrv[g]),
                .rsp_ready (1'b1),
                .rsp_rdata (lrd[g]),
                .rsp_err   (lerr[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One transaction on the main instance with rsp_ready held high
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd, input string name);
        int acc;
        int t;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_accept_timeout"}, 32'(req_ready), 32'd1);
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
        chk({name, "_latency"}, 32'(cyc - acc), 32'(c_LAT));
        chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({name, "_rdata"}, rsp_rdata, exp_rd);
    endtask

    // Store then two back-to-back loads on a latency instance; measures timing
    task automatic run_lat(input int g, input int lat, input logic [31:0] w);
        int          acc [3];
        int          rsp [3];
        logic [31:0] rd  [3];
        int          na;
        int          nr;
        logic        prev;
        string       nm;
        na = 0;
        nr = 0;
        prev = 1'b0;
        nm = $sformatf("lat%0d", lat);
        @(negedge clk);
        lw[g]  = 1'b1;
        la[g]  = 32'h20;
        lwd[g] = w;
        lv[g]  = 1'b1;
        for (int t = 0; t < 200 && nr < 3; t++) begin
            if (lrv[g] && !prev) begin
                rsp[nr] = cyc;
                rd[nr]  = lrd[g];
                chk({nm, "_err"}, 32'(lerr[g]), 32'd0);
                nr++;
            end
            prev = lrv[g];
            if (na >= 1 && !lrdy[g]) lw[g] = 1'b0;
            if (na >= 3 && !lrdy[g]) lv[g] = 1'b0;
            if (lv[g] && lrdy[g] && na < 3) begin
                acc[na] = cyc + 1;
                na++;
            end
            @(negedge clk);
        end
        lv[g] = 1'b0;
        chk({nm, "_rsp_count"}, 32'(nr), 32'd3);
        for (int i = 0; i < nr; i++) begin
            chk($sformatf("%s_latency%0d", nm, i), 32'(rsp[i] - acc[i]), 32'(lat));
            chk($sformatf("%s_rdata%0d", nm, i), rd[i], (i == 0) ? 32'h0 : w);
        end
        for (int i = 0; i + 1 < na && i < 2; i++) begin
            chk($sformatf("%s_period%0d", nm, i), 32'(acc[i+1] - acc[i]), 32'(lat + 2));
        end
        repeat (lat + 4) @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int acc;
        int t;

        for (int g = 0; g < 2; g++) begin
            lv[g] = 1'b0; lw[g] = 1'b0; la[g] = '0; lwd[g] = '0;
        end

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0013, 32'h1234_5678, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0BAD_F00D};
        vecs[7] = '{1'b1, 32'h8000_0010, 32'h7777_7777, 1'b1, 32'h0};
        vecs[8] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("post_reset_rsp_err", 32'(rsp_err), 32'd0);

        // Table-driven transactions
        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].err, vecs[i].rd,
                $sformatf("vec%0d", i));
        end

        // Response held off for 5 cycles; stray request must be ignored
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = '0;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 40) begin @(negedge clk); t++; end
        chk("hold_latency", 32'(cyc - acc), 32'(c_LAT));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_rsp_valid%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold_rdata%0d", i), rsp_rdata, 32'hDEAD_BEEF);
            chk($sformatf("hold_req_ready%0d", i), 32'(req_ready), 32'd0);
            if (i == 1) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h1111_1111;
            end
            if (i == 2) req_valid = 1'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        chk("release_rdata", rsp_rdata, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "after_hold");

        // Reset while a store is pending in S_WAIT
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFE_F00D;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("wait_rst_req_ready", 32'(req_ready), 32'd1);
        chk("wait_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "wait_rst_load");

        // Reset while a store response is held in S_RESP
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555_AAAA;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 40) begin @(negedge clk); t++; end
        chk("resp_rst_pre_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("resp_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("resp_rst_req_ready", 32'(req_ready), 32'd1);
        txn(1'b0, 32'h20, 32'h0, 1'b0, 32'h5555_AAAA, "resp_rst_load");

        // Latency extremes
        run_lat(0, 1, 32'hA5A5_0001);
        run_lat(1, 15, 32'hA5A5_000F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
